// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter and its input conditioning.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        CAPTURE
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Metastability synchronizer followed by a one-flop rising-edge detector.
module edge_sync
    import freq_meter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    // Bits [SYNC_STAGES-1:0] form the synchronizer; the top bit is the delayed copy for edge detection.
    logic [SYNC_STAGES:0] shift_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= {shift_q[SYNC_STAGES-1:0], async_in};
        end
    end

    assign rise = shift_q[SYNC_STAGES-1] & ~shift_q[SYNC_STAGES];

endmodule

// File: rtl/freq_meter.sv
// Counts synchronized rising edges of sig_in over a gate of GATE_CYCLES clocks and reports the total.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int GATE_W      = 26,
    parameter int CNT_W       = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             gate_open
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d, edge_next;
    logic              sat_q, sat_d, sat_next;
    logic [CNT_W-1:0]  freq_q, freq_d;
    logic              overflow_q, overflow_d;
    logic              freq_valid_q, freq_valid_d;
    logic              rise;

    edge_sync u_edge_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (sig_in),
        .rise     (rise)
    );

    // Results are loaded on the way into CAPTURE so freq already holds the new value while freq_valid is high.
    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = '0;
        edge_cnt_d   = '0;
        sat_d        = 1'b0;
        freq_d       = freq_q;
        overflow_d   = overflow_q;
        freq_valid_d = 1'b0;
        edge_next    = edge_cnt_q;
        sat_next     = sat_q;

        if (rise) begin
            if (edge_cnt_q == '1) begin
                sat_next = 1'b1;
            end else begin
                edge_next = edge_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = GATE;
                end
            end
            GATE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (gate_cnt_q == GATE_LAST) begin
                    state_d      = CAPTURE;
                    freq_d       = edge_next;
                    overflow_d   = sat_next;
                    freq_valid_d = 1'b1;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                    edge_cnt_d = edge_next;
                    sat_d      = sat_next;
                end
            end
            CAPTURE: begin
                state_d = enable ? GATE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            freq_q       <= '0;
            overflow_q   <= 1'b0;
            freq_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            sat_q        <= sat_d;
            freq_q       <= freq_d;
            overflow_q   <= overflow_d;
            freq_valid_q <= freq_valid_d;
        end
    end

    assign freq       = freq_q;
    assign overflow   = overflow_q;
    assign freq_valid = freq_valid_q;
    assign gate_open  = (state_q == GATE);

endmodule
